// File: rtl/instruction_fetch_decode.sv
// instruction_fetch_decode
//   IF/ID front end of the 16-bit two-register (A/B) pipeline. A 1024x16
//   combinational instruction ROM is read at iPC, the fetched word is
//   captured in the IF/ID register, and the registered word is decoded into
//   the EX/MEM/WB control signals. The ALU operation itself is derived
//   downstream from oInst[15:10].
//
// Ports
//   Clock          in   rising-edge clock
//   Reset          in   synchronous, active-high; clears the IF/ID register
//   Enable         in   1 = load IF/ID register, 0 = hold (stall)
//   iPC            in   fetch address (wraps at 10 bits)
//   oInstruction   out  ROM[iPC], combinational
//   oInst          out  IF/ID registered instruction
//   oConst         out  oInst[9:0]
//   oWriteToA      out  instruction writes register A
//   oWriteToB      out  instruction writes register B
//   oMuxPreAluA    out  0 = ALU in A from reg A, 1 = from const
//   oMuxPreAluB    out  0 = ALU in B from reg B, 1 = from const
//   oReadWrite     out  1 = data memory write, 0 = read
//   oWriteBackMux  out  1 = write-back from memory, 0 = from ALU
//   oWriteMux      out  store data select: 00 = A, 01 = B, 1x reserved
//   oJump          out  unconditional jump to const
//   oBranchTaken   out  branch condition code, 0000 = no branch
//
// The PATCH_* parameters overlay a window of words onto the ROM image
// (e.g. to load a different program). The default overlays a single NOP at
// address 20, which leaves the built-in program unchanged.
module instruction_fetch_decode #(
  parameter int                              ROM_DEPTH   = 1024,
  parameter int                              INST_WIDTH  = 16,
  parameter int                              PATCH_N     = 1,
  parameter logic [9:0]                      PATCH_BASE  = 10'd20,
  parameter logic [PATCH_N*INST_WIDTH-1:0]   PATCH_WORDS = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [9:0]            iPC,
  output logic [INST_WIDTH-1:0] oInstruction,
  output logic [INST_WIDTH-1:0] oInst,
  output logic [9:0]            oConst,
  output logic                  oWriteToA,
  output logic                  oWriteToB,
  output logic                  oMuxPreAluA,
  output logic                  oMuxPreAluB,
  output logic                  oReadWrite,
  output logic                  oWriteBackMux,
  output logic [1:0]            oWriteMux,
  output logic                  oJump,
  output logic [3:0]            oBranchTaken
);

  localparam int ADDR_W = 10;

  typedef enum logic [5:0] {
    OP_NOP   = 6'h00,
    OP_LDA   = 6'h01,
    OP_LDB   = 6'h02,
    OP_STA   = 6'h03,
    OP_STB   = 6'h04,
    OP_LDCA  = 6'h05,
    OP_LDCB  = 6'h06,
    OP_ADDA  = 6'h07,
    OP_ADDB  = 6'h08,
    OP_SUBA  = 6'h09,
    OP_SUBB  = 6'h0A,
    OP_ADDCA = 6'h0B,
    OP_ADDCB = 6'h0C,
    OP_ANDA  = 6'h0D,
    OP_ORA   = 6'h0E,
    OP_BAEQ  = 6'h10,
    OP_BANE  = 6'h11,
    OP_BBEQ  = 6'h12,
    OP_BBNE  = 6'h13,
    OP_JMP   = 6'h18
  } opcode_e;

  logic [INST_WIDTH-1:0] rom [0:ROM_DEPTH-1];
  logic [INST_WIDTH-1:0] inst_p0;
  logic [5:0]            opcode;

  // Fetch: program image, every address defined (NOP where unused)
  always_comb begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
    rom[0] = 16'h1405;
    rom[1] = 16'h1803;
    rom[2] = 16'h1C00;
    rom[3] = 16'h0C10;
    rom[4] = 16'h0810;
    rom[5] = 16'h2400;
    rom[6] = 16'h400A;
    rom[7] = 16'h6000;
    for (int k = 0; k < PATCH_N; k++)
      rom[ADDR_W'(int'(PATCH_BASE) + k)] = PATCH_WORDS[k*INST_WIDTH +: INST_WIDTH];
  end

  assign oInstruction = rom[iPC];

  // IF/ID boundary: reset wins over Enable; Enable=0 stalls
  always_ff @(posedge Clock) begin
    if (Reset)       inst_p0 <= '0;
    else if (Enable) inst_p0 <= oInstruction;
  end

  assign oInst  = inst_p0;
  assign oConst = inst_p0[9:0];
  assign opcode = inst_p0[15:10];

  // Decode: combinational from the IF/ID word; unlisted opcodes act as NOP
  always_comb begin
    oWriteToA     = 1'b0;
    oWriteToB     = 1'b0;
    oMuxPreAluA   = 1'b0;
    oMuxPreAluB   = 1'b0;
    oReadWrite    = 1'b0;
    oWriteBackMux = 1'b0;
    oWriteMux     = 2'b00;
    oJump         = 1'b0;
    oBranchTaken  = 4'b0000;
    case (opcode)
      OP_LDA:   begin oWriteToA = 1'b1; oWriteBackMux = 1'b1; end
      OP_LDB:   begin oWriteToB = 1'b1; oWriteBackMux = 1'b1; end
      OP_STA:   begin oReadWrite = 1'b1; oWriteMux = 2'b00; end
      OP_STB:   begin oReadWrite = 1'b1; oWriteMux = 2'b01; end
      OP_LDCA:  begin oWriteToA = 1'b1; oMuxPreAluB = 1'b1; end
      OP_LDCB:  begin oWriteToB = 1'b1; oMuxPreAluB = 1'b1; end
      OP_ADDA:  oWriteToA = 1'b1;
      OP_ADDB:  oWriteToB = 1'b1;
      OP_SUBA:  oWriteToA = 1'b1;
      OP_SUBB:  oWriteToB = 1'b1;
      OP_ADDCA: begin oWriteToA = 1'b1; oMuxPreAluB = 1'b1; end
      // ADDCB routes the constant through ALU input A, unlike ADDCA
      OP_ADDCB: begin oWriteToB = 1'b1; oMuxPreAluA = 1'b1; end
      OP_ANDA:  oWriteToA = 1'b1;
      OP_ORA:   oWriteToA = 1'b1;
      OP_BAEQ:  oBranchTaken = 4'b0001;
      OP_BANE:  oBranchTaken = 4'b0010;
      OP_BBEQ:  oBranchTaken = 4'b0011;
      OP_BBNE:  oBranchTaken = 4'b0100;
      OP_JMP:   oJump = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_decode.sv
module tb_instruction_fetch_decode;

  // Patch window: address 20+k holds opcode (63-k) with const (1023-k),
  // so every one of the 64 opcodes is fetched and decoded once.
  localparam int         PN    = 64;
  localparam logic [9:0] PBASE = 10'd20;

  function automatic logic [PN*16-1:0] mk_patch();
    logic [PN*16-1:0] p;
    p = '0;
    for (int k = 0; k < PN; k++) p[k*16 +: 16] = {6'(63 - k), 10'(1023 - k)};
    return p;
  endfunction

  localparam logic [PN*16-1:0] PATCH = mk_patch();

  // Control vector layout: WA WB MA MB RW WBM WM[1:0] J BR[3:0]
  localparam logic [12:0] C_WA  = 13'h1000;
  localparam logic [12:0] C_WB  = 13'h0800;
  localparam logic [12:0] C_MA  = 13'h0400;
  localparam logic [12:0] C_MB  = 13'h0200;
  localparam logic [12:0] C_RW  = 13'h0100;
  localparam logic [12:0] C_WBM = 13'h0080;
  localparam logic [12:0] C_WM1 = 13'h0020;
  localparam logic [12:0] C_J   = 13'h0010;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [9:0]  iPC = '0;
  logic [15:0] oInstruction, oInst;
  logic [9:0]  oConst;
  logic        oWriteToA, oWriteToB, oMuxPreAluA, oMuxPreAluB;
  logic        oReadWrite, oWriteBackMux, oJump;
  logic [1:0]  oWriteMux;
  logic [3:0]  oBranchTaken;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [15:0] rom_m [0:1023];
  logic [12:0] ctrl_tbl [0:63];
  logic [15:0] exp_inst = '0;
  logic [12:0] ctrl;

  instruction_fetch_decode #(
    .ROM_DEPTH(1024), .INST_WIDTH(16),
    .PATCH_N(PN), .PATCH_BASE(PBASE), .PATCH_WORDS(PATCH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .iPC(iPC),
    .oInstruction(oInstruction), .oInst(oInst), .oConst(oConst),
    .oWriteToA(oWriteToA), .oWriteToB(oWriteToB),
    .oMuxPreAluA(oMuxPreAluA), .oMuxPreAluB(oMuxPreAluB),
    .oReadWrite(oReadWrite), .oWriteBackMux(oWriteBackMux),
    .oWriteMux(oWriteMux), .oJump(oJump), .oBranchTaken(oBranchTaken)
  );

  always #5 Clock = ~Clock;

  assign ctrl = {oWriteToA, oWriteToB, oMuxPreAluA, oMuxPreAluB, oReadWrite,
                 oWriteBackMux, oWriteMux, oJump, oBranchTaken};

  // Reference IF/ID word
  always @(posedge Clock) begin
    if (Reset)       exp_inst <= 16'h0000;
    else if (Enable) exp_inst <= rom_m[iPC];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the reference
  always @(negedge Clock) begin
    if (chk_en) begin
      check("fetch", oInstruction, rom_m[iPC]);
      check("ifid", oInst, exp_inst);
      check("const", {6'd0, oConst}, {6'd0, exp_inst[9:0]});
      check("ctrl", {3'd0, ctrl}, {3'd0, ctrl_tbl[exp_inst[15:10]]});
    end
  end

  task automatic cyc(input logic rst, input logic en, input logic [9:0] pc);
    Reset = rst; Enable = en; iPC = pc;
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_m[i] = 16'h0000;
    rom_m[0] = 16'h1405; rom_m[1] = 16'h1803; rom_m[2] = 16'h1C00; rom_m[3] = 16'h0C10;
    rom_m[4] = 16'h0810; rom_m[5] = 16'h2400; rom_m[6] = 16'h400A; rom_m[7] = 16'h6000;
    for (int k = 0; k < PN; k++) rom_m[int'(PBASE) + k] = {6'(63 - k), 10'(1023 - k)};

    for (int i = 0; i < 64; i++) ctrl_tbl[i] = 13'h0;
    ctrl_tbl[6'h01] = C_WA | C_WBM;  ctrl_tbl[6'h02] = C_WB | C_WBM;
    ctrl_tbl[6'h03] = C_RW;          ctrl_tbl[6'h04] = C_RW | C_WM1;
    ctrl_tbl[6'h05] = C_WA | C_MB;   ctrl_tbl[6'h06] = C_WB | C_MB;
    ctrl_tbl[6'h07] = C_WA;          ctrl_tbl[6'h08] = C_WB;
    ctrl_tbl[6'h09] = C_WA;          ctrl_tbl[6'h0A] = C_WB;
    ctrl_tbl[6'h0B] = C_WA | C_MB;   ctrl_tbl[6'h0C] = C_WB | C_MA;
    ctrl_tbl[6'h0D] = C_WA;          ctrl_tbl[6'h0E] = C_WA;
    ctrl_tbl[6'h10] = 13'h0001;      ctrl_tbl[6'h11] = 13'h0002;
    ctrl_tbl[6'h12] = 13'h0003;      ctrl_tbl[6'h13] = 13'h0004;
    ctrl_tbl[6'h18] = C_J;

    // Reset
    cyc(1'b1, 1'b0, 10'd0);
    chk_en = 1'b1;
    check("rst_inst", oInst, 16'h0000);
    check("rst_ctrl", {3'd0, ctrl}, 16'h0000);
    check("rst_const", {6'd0, oConst}, 16'h0000);
    cyc(1'b1, 1'b1, 10'd3);
    check("rst_over_en", oInst, 16'h0000);
    check("rom3_comb", oInstruction, 16'h0C10);

    // Sweep 0..12 with literal spot checks
    for (int p = 0; p <= 12; p++) begin
      cyc(1'b0, 1'b1, 10'(p));
      case (p)
        0: begin
          check("pc0_inst", oInst, 16'h1405);
          check("pc0_wa", {15'd0, oWriteToA}, 16'd1);
          check("pc0_mb", {15'd0, oMuxPreAluB}, 16'd1);
          check("pc0_const", {6'd0, oConst}, 16'd5);
        end
        3: begin
          check("pc3_rw", {15'd0, oReadWrite}, 16'd1);
          check("pc3_wm", {14'd0, oWriteMux}, 16'd0);
          check("pc3_const", {6'd0, oConst}, 16'h010);
        end
        4: begin
          check("pc4_wb", {15'd0, oWriteToB}, 16'd1);
          check("pc4_wbm", {15'd0, oWriteBackMux}, 16'd1);
        end
        6: begin
          check("pc6_br", {12'd0, oBranchTaken}, 16'd1);
          check("pc6_const", {6'd0, oConst}, 16'd10);
        end
        7: begin
          check("pc7_jmp", {15'd0, oJump}, 16'd1);
          check("pc7_const", {6'd0, oConst}, 16'd0);
        end
        8: check("pc8_nop", {3'd0, ctrl}, 16'h0000);
        default: ;
      endcase
    end

    // Stall: hold the BAEQ word while iPC moves
    cyc(1'b0, 1'b1, 10'd6);
    cyc(1'b0, 1'b0, 10'd1);
    cyc(1'b0, 1'b0, 10'd2);
    check("stall_inst", oInst, 16'h400A);
    check("stall_br", {12'd0, oBranchTaken}, 16'd1);
    cyc(1'b0, 1'b1, 10'd2);
    check("resume_inst", oInst, 16'h1C00);

    // Reset mid-program, then resume from iPC
    cyc(1'b0, 1'b1, 10'd0);
    cyc(1'b1, 1'b1, 10'd1);
    check("midrst_inst", oInst, 16'h0000);
    cyc(1'b0, 1'b1, 10'd5);
    check("after_rst", oInst, 16'h2400);
    check("after_rst_wa", {15'd0, oWriteToA}, 16'd1);

    // Every opcode through the patch window; address 20 carries opcode 3F
    for (int k = 0; k < PN; k++) begin
      cyc(1'b0, 1'b1, 10'(int'(PBASE) + k));
      if (k == 0) begin
        check("ill3f_inst", oInst, 16'hFFFF);
        check("ill3f_ctrl", {3'd0, ctrl}, 16'h0000);
        check("ill3f_const", {6'd0, oConst}, 16'h03FF);
      end
      if (k == 51) begin
        check("addcb_ma", {15'd0, oMuxPreAluA}, 16'd1);
        check("addcb_wb", {15'd0, oWriteToB}, 16'd1);
      end
    end

    // Top address and wrap back to 0
    cyc(1'b0, 1'b1, 10'd1023);
    check("top_nop", oInst, 16'h0000);
    cyc(1'b0, 1'b1, 10'd1023 + 10'd1);
    check("wrap_inst", oInst, 16'h1405);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
